pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the next generation of the ID/EX latch, reusable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries N_WORDS data words, a tag field (funct/rd bits) and a control-signal vector.
- Adds a valid bit, hazard-unit stall (hold) and flush (bubble insertion).
- Bubbles zero the control vector so no downstream write or branch can fire.
- Optional saturating performance counters for stalls and bubbles.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline inter-stage registers:
//   - default widths for data words, tag field, control vector and counters
//   - ID/EX control-vector bit positions
//   - 2-bit ALU-op encoding carried in the EX control field
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Default widths (ID/EX flavour of the stage register)
   localparam int DATA_W_DEF  = 32;
   localparam int N_WORDS_DEF = 4;   // pc, rs1 data, rs2 data, imm
   localparam int TAG_W_DEF   = 9;   // funct 4 + rd 5
   localparam int CTRL_W_DEF  = 8;   // WB 2 + MEM 3 + EX 3
   localparam int CNT_W_DEF   = 16;

   // ID/EX control-vector bit indices
   localparam int CTRL_WB_REG_WRITE  = 7;
   localparam int CTRL_WB_MEM_TO_REG = 6;
   localparam int CTRL_M_BRANCH      = 5;
   localparam int CTRL_M_MEM_READ    = 4;
   localparam int CTRL_M_MEM_WRITE   = 3;
   localparam int CTRL_EX_ALU_OP_HI  = 2;
   localparam int CTRL_EX_ALU_OP_LO  = 1;
   localparam int CTRL_EX_ALU_SRC    = 0;

   // ALU-op encoding in ctrl[CTRL_EX_ALU_OP_HI:CTRL_EX_ALU_OP_LO]
   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'b00,   // loads/stores: address add
      ALU_OP_BRANCH = 2'b01,   // branch compare (subtract)
      ALU_OP_FUNCT  = 2'b10,   // R-type: decode funct bits
      ALU_OP_RSVD   = 2'b11
   } alu_op_e;

   // Extract the ALU-op field from an ID/EX control vector
   function automatic alu_op_e ctrl_alu_op(input logic [CTRL_W_DEF-1:0] ctrl);
      return alu_op_e'(ctrl[CTRL_EX_ALU_OP_HI:CTRL_EX_ALU_OP_LO]);
   endfunction

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the stage performance counters. Counts one
// per clock while inc is high, sticks at all-ones, never wraps.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset, clears count
//   inc    in   increment request for this edge
//   count  out  current count (CNT_W bits)
// -----------------------------------------------------------------------------
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries N_WORDS data words, a tag field and a control vector plus a valid
// bit. Hazard unit controls: stall holds the stage, flush writes a bubble.
// Edge priority: reset > flush > stall > load. A bubble always carries an
// all-zero control vector, so nothing downstream can write or branch.
//
// Build option: define PIPE_STAGE_PERF_EN to instantiate the saturating
// stall/bubble counters; otherwise both counter outputs are tied to zero.
// The port list is identical in both builds.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   stall         in   hold all stage contents this cycle
//   flush         in   replace stage contents with a bubble this cycle
//   in_valid      in   upstream slot holds a real instruction
//   in_words      in   packed data words, word 0 in the LSBs
//   in_tag        in   tag field (funct/rd bits)
//   in_ctrl       in   control vector
//   out_valid     out  registered valid
//   out_words     out  registered data words
//   out_tag       out  registered tag
//   out_ctrl      out  registered control, zero whenever out_valid = 0
//   stall_count   out  edges with stall applied (saturating)
//   bubble_count  out  bubbles written into the stage (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int N_WORDS = N_WORDS_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int CTRL_W  = CTRL_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [N_WORDS*DATA_W-1:0] in_words,
   input  logic [TAG_W-1:0]          in_tag,
   input  logic [CTRL_W-1:0]         in_ctrl,
   output logic                      out_valid,
   output logic [N_WORDS*DATA_W-1:0] out_words,
   output logic [TAG_W-1:0]          out_tag,
   output logic [CTRL_W-1:0]         out_ctrl,
   output logic [CNT_W-1:0]          stall_count,
   output logic [CNT_W-1:0]          bubble_count
);

   // Stage register. A flush leaves words/tag untouched: they are don't-care
   // while out_valid is low and holding them saves enable logic.
   // NOTE: the payload registers are reset too, because their reset value
   // (all zero) is visible on the outputs and downstream may sample it.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_words <= '0;
         out_tag   <= '0;
         out_ctrl  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end else if (!stall) begin
         out_valid <= in_valid;
         out_words <= in_words;
         out_tag   <= in_tag;
         out_ctrl  <= in_valid ? in_ctrl : '0;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic stall_inc;
   logic bubble_inc;

   // A bubble is written by a flush, or by a load of an empty upstream slot.
   assign stall_inc  = !reset && stall && !flush;
   assign bubble_inc = !reset && (flush || (!stall && !in_valid));

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (bubble_inc),
      .count (bubble_count)
   );
`else
   assign stall_count  = '0;
   assign bubble_count = '0;
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. Two instances share all inputs: one
// with default widths and one with a 3-bit counter width for saturation.
// Expected values come from a behavioural model of the stage rules.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int DATA_W  = 32;
   localparam int N_WORDS = 4;
   localparam int TAG_W   = 9;
   localparam int CTRL_W  = 8;
   localparam int CNT_W   = 16;
   localparam int SAT_W   = 3;
   localparam int W_BITS  = N_WORDS * DATA_W;

`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              stall;
   logic              flush;
   logic              in_valid;
   logic [W_BITS-1:0] in_words;
   logic [TAG_W-1:0]  in_tag;
   logic [CTRL_W-1:0] in_ctrl;

   logic              out_valid;
   logic [W_BITS-1:0] out_words;
   logic [TAG_W-1:0]  out_tag;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  bubble_count;

   logic              s_valid;
   logic [W_BITS-1:0] s_words;
   logic [TAG_W-1:0]  s_tag;
   logic [CTRL_W-1:0] s_ctrl;
   logic [SAT_W-1:0]  s_stall_count;
   logic [SAT_W-1:0]  s_bubble_count;

   always #5 clock = ~clock;

   pipe_stage_reg #(
      .DATA_W(DATA_W), .N_WORDS(N_WORDS), .TAG_W(TAG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_words     (in_words),
      .in_tag       (in_tag),
      .in_ctrl      (in_ctrl),
      .out_valid    (out_valid),
      .out_words    (out_words),
      .out_tag      (out_tag),
      .out_ctrl     (out_ctrl),
      .stall_count  (stall_count),
      .bubble_count (bubble_count)
   );

   pipe_stage_reg #(
      .DATA_W(DATA_W), .N_WORDS(N_WORDS), .TAG_W(TAG_W), .CTRL_W(CTRL_W), .CNT_W(SAT_W)
   ) dut_sat (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_words     (in_words),
      .in_tag       (in_tag),
      .in_ctrl      (in_ctrl),
      .out_valid    (s_valid),
      .out_words    (s_words),
      .out_tag      (s_tag),
      .out_ctrl     (s_ctrl),
      .stall_count  (s_stall_count),
      .bubble_count (s_bubble_count)
   );

   // Behavioural model state
   bit                m_valid;
   logic [W_BITS-1:0] m_words;
   logic [TAG_W-1:0]  m_tag;
   logic [CTRL_W-1:0] m_ctrl;
   bit                m_known;     // words/tag are defined (not after a flush)
   int                m_stall, m_bub, m_stall_s, m_bub_s;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int MAX_BIG = (1 << CNT_W) - 1;
   localparam int MAX_SAT = (1 << SAT_W) - 1;

   function automatic int sat_add(input int v, input int maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Apply the stage rules to the inputs present at this edge.
   task automatic model_edge();
      if (reset) begin
         m_valid = 0; m_words = '0; m_tag = '0; m_ctrl = '0; m_known = 1;
         m_stall = 0; m_bub = 0; m_stall_s = 0; m_bub_s = 0;
      end else if (flush) begin
         m_valid = 0; m_ctrl = '0; m_known = 0;
         m_bub   = sat_add(m_bub, MAX_BIG);
         m_bub_s = sat_add(m_bub_s, MAX_SAT);
      end else if (stall) begin
         m_stall   = sat_add(m_stall, MAX_BIG);
         m_stall_s = sat_add(m_stall_s, MAX_SAT);
      end else begin
         m_valid = in_valid;
         m_words = in_words;
         m_tag   = in_tag;
         m_ctrl  = in_valid ? in_ctrl : '0;
         m_known = 1;
         if (!in_valid) begin
            m_bub   = sat_add(m_bub, MAX_BIG);
            m_bub_s = sat_add(m_bub_s, MAX_SAT);
         end
      end
   endtask

   task automatic compare_all();
      check("valid", 128'(out_valid), 128'(m_valid));
      check("ctrl",  128'(out_ctrl),  128'(m_ctrl));
      if (m_known) begin
         check("words", 128'(out_words), 128'(m_words));
         check("tag",   128'(out_tag),   128'(m_tag));
      end
      check("stall_count",    128'(stall_count),    128'(PERF ? m_stall : 0));
      check("bubble_count",   128'(bubble_count),   128'(PERF ? m_bub : 0));
      check("sat_valid",      128'(s_valid),        128'(m_valid));
      check("sat_ctrl",       128'(s_ctrl),         128'(m_ctrl));
      check("sat_stall_count",  128'(s_stall_count),  128'(PERF ? m_stall_s : 0));
      check("sat_bubble_count", 128'(s_bubble_count), 128'(PERF ? m_bub_s : 0));
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   function automatic logic [W_BITS-1:0] rand_words();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   int bub_before;

   initial begin
      reset = 1; stall = 0; flush = 0; in_valid = 0;
      in_words = '0; in_tag = '0; in_ctrl = '0;
      m_valid = 0; m_words = '0; m_tag = '0; m_ctrl = '0; m_known = 0;
      m_stall = 0; m_bub = 0; m_stall_s = 0; m_bub_s = 0;

      // Reset for two cycles: everything zero
      tick();
      tick();
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_words", 128'(out_words), 128'(0));
      check("rst_ctrl",  128'(out_ctrl),  128'(0));

      // Reset then load
      reset = 0; in_valid = 1;
      in_words = {rand_words()} & ~128'hFFFF_FFFF | 128'h0000_0040;
      in_ctrl = 8'hA5; in_tag = 9'h1F3;
      tick();
      check("load_valid", 128'(out_valid),         128'(1));
      check("load_ctrl",  128'(out_ctrl),          128'(8'hA5));
      check("load_word0", 128'(out_words[31:0]),   128'(32'h40));
      check("load_tag",   128'(out_tag),           128'(9'h1F3));

      // Stall hold: load 0xFF then stall 3 cycles with changing inputs
      in_ctrl = 8'hFF; in_words = rand_words();
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         in_ctrl = 8'h01; in_words = rand_words(); in_tag = 9'(i);
         tick();
      end
      check("stall_hold_ctrl", 128'(out_ctrl),    128'(8'hFF));
      check("stall_cnt3",      128'(stall_count), 128'(PERF ? 3 : 0));

      // Flush priority over stall
      stall = 0; in_valid = 1; in_ctrl = 8'h3C;
      tick();
      bub_before = m_bub;
      stall = 1; flush = 1;
      tick();
      check("flush_valid",     128'(out_valid),    128'(0));
      check("flush_ctrl",      128'(out_ctrl),     128'(0));
      check("flush_stall_cnt", 128'(stall_count),  128'(PERF ? 3 : 0));
      check("flush_bub_cnt",   128'(bubble_count), 128'(PERF ? bub_before + 1 : 0));

      // Invalid input load
      stall = 0; flush = 0; in_valid = 0; in_ctrl = 8'hFF; in_words = rand_words();
      tick();
      check("inv_valid", 128'(out_valid), 128'(0));
      check("inv_ctrl",  128'(out_ctrl),  128'(0));
      check("inv_words", 128'(out_words), 128'(in_words));

      // Saturation of the 3-bit instance
      stall = 1;
      for (int i = 0; i < 10; i++) tick();
      check("sat_stall_7",  128'(s_stall_count), 128'(PERF ? 7 : 0));
      tick();
      tick();
      check("sat_stall_hold", 128'(s_stall_count), 128'(PERF ? 7 : 0));

      // Reset mid-stall with counters nonzero
      reset = 1;
      tick();
      check("mid_rst_valid",  128'(out_valid),    128'(0));
      check("mid_rst_ctrl",   128'(out_ctrl),     128'(0));
      check("mid_rst_words",  128'(out_words),    128'(0));
      check("mid_rst_tag",    128'(out_tag),      128'(0));
      check("mid_rst_stallc", 128'(stall_count),  128'(0));
      check("mid_rst_bubc",   128'(bubble_count), 128'(0));
      reset = 0; stall = 0;

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 99) < 2);
         stall    = ($urandom_range(0, 99) < 30);
         flush    = ($urandom_range(0, 99) < 15);
         in_valid = ($urandom_range(0, 99) < 70);
         in_words = rand_words();
         in_tag   = TAG_W'($urandom());
         in_ctrl  = CTRL_W'($urandom());
         tick();
      end

      // Long stall run to push the 3-bit counters into saturation again
      reset = 0; flush = 0; stall = 1;
      for (int i = 0; i < 12; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
